// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Signed MULT/DIV support is compiled in only when MDU_SIGNED_EN is defined.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWE,
    input  logic             loWE,
    input  logic [WIDTH-1:0] wData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    // control state (reset)
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // working datapath (captured at launch, no reset needed)
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;

    // operand magnitudes presented at launch
    logic [WIDTH-1:0] a_mag, b_mag;

    // step results
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    // final results after sign correction
    logic [WIDTH-1:0] fin_hi, fin_lo;

`ifdef MDU_SIGNED_EN
    logic neg_a_q, neg_a_d;
    logic neg_b_q, neg_b_d;
    logic a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                           input logic neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return neg ? -s : s;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v,
                                                              input logic neg);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(v);
        return neg ? -s : s;
    endfunction

    always_comb begin
        a_neg = op[0] & srcA[WIDTH-1];
        b_neg = op[0] & srcB[WIDTH-1];
        a_mag = apply_sign(srcA, a_neg);
        b_mag = apply_sign(srcB, b_neg);
    end

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_comb begin
        prod_fix = apply_sign2({acc_hi_q, acc_lo_q}, neg_a_q ^ neg_b_q);
        if (is_div_q) begin
            fin_hi = apply_sign(acc_hi_q, neg_a_q);
            fin_lo = div0_q ? {WIDTH{1'b1}} : apply_sign(acc_lo_q, neg_a_q ^ neg_b_q);
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        neg_a_q <= neg_a_d;
        neg_b_q <= neg_b_d;
    end

    always_comb begin
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        if (state_q == IDLE && start) begin
            neg_a_d = a_neg;
            neg_b_d = b_neg;
        end
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[0];

    always_comb begin
        a_mag = srcA;
        b_mag = srcB;
    end

    always_comb begin
        fin_hi = acc_hi_q;
        fin_lo = (is_div_q && div0_q) ? {WIDTH{1'b1}} : acc_lo_q;
    end
`endif

    // Shift-add multiply: acc_lo holds the multiplier and collects product bits from the top.
    // Restoring divide: acc_lo holds the dividend and collects quotient bits from the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opnd_q};
        div_sub   = div_trial[WIDTH-1:0] - opnd_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;

        case (state_q)
            IDLE: begin
                if (hiWE) hi_d = wData;
                if (loWE) lo_d = wData;
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    div0_d   = op[1] && (srcB == '0);
                    acc_hi_d = '0;
                    acc_lo_d = op[1] ? a_mag : b_mag;
                    opnd_d   = op[1] ? b_mag : a_mag;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_sub : div_trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = FIN;
                    cnt_d   = '0;
                end
            end
            FIN: begin
                hi_d    = fin_hi;
                lo_d    = fin_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        opnd_q   <= opnd_d;
        is_div_q <= is_div_d;
        div0_q   <= div0_d;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of MULT/DIV vectors plus handshake, MTHI/MTLO and reset sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB, wData;
    logic        hiWE, loWE;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hiWE(hiWE), .loWE(loWE), .wData(wData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble operands after capture, wait for done and check everything.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        int early_idle;
        bit got;
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; srcA = $urandom; srcB = $urandom; op = 2'($urandom);
        check({tag, " busy_at_launch"}, {31'b0, busy}, 32'd1);
        cyc = 0; got = 1'b0; early_idle = 0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
            else if (!busy) early_idle++;
        end
        check({tag, " latency"}, cyc, 32'd33);
        check({tag, " busy_gap"}, early_idle, 32'd0);
        check({tag, " busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " lo_hold"}, lo, elo);
    endtask

    initial begin
        int pulses;
        int dcyc;
        int ndone;

        vt[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vt[1] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vt[2] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vt[3] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[4] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vt[5] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vt[6] = '{2'b10, 32'd5,        32'd10,       32'd5,        32'd0};
        vt[12] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
`ifdef MDU_SIGNED_EN
        vt[7]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[8]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[9]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[10] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vt[13] = '{2'b01, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
`else
        vt[7]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
        vt[8]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vt[9]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vt[10] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000};
        vt[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[13] = '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
`endif

        rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hiWE = 1'b0; loWE = 1'b0; wData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);
        end

        // Second start and MTHI/MTLO in the middle of a MULTU must be dropped.
        op = 2'b00; srcA = 32'd6; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; dcyc = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin
                start = 1'b1; op = 2'b10; srcA = 32'd100; srcB = 32'd7;
                hiWE = 1'b1; loWE = 1'b1; wData = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            start = 1'b0; hiWE = 1'b0; loWE = 1'b0;
            if (done) begin
                pulses++;
                dcyc = c;
            end
        end
        check("hs pulses", pulses, 32'd1);
        check("hs latency", dcyc, 32'd33);
        check("hs hi", hi, 32'd0);
        check("hs lo", lo, 32'd42);

        // Reset in the middle of a DIVU aborts it and clears HI/LO.
        op = 2'b10; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst done", ndone + int'(done), 32'd0);
        rst = 1'b0;
        run_op("post_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        // MTHI then MTLO in IDLE.
        hiWE = 1'b1; wData = 32'hA5A5A5A5;
        @(posedge clk); #1;
        hiWE = 1'b0;
        check("mthi hi", hi, 32'hA5A5A5A5);
        check("mthi lo", lo, 32'd14);
        check("mthi done", {31'b0, done}, 32'd0);
        loWE = 1'b1; wData = 32'h5A5A5A5A;
        @(posedge clk); #1;
        loWE = 1'b0;
        check("mtlo lo", lo, 32'h5A5A5A5A);
        check("mtlo hi", hi, 32'hA5A5A5A5);

        // Start and MTLO on the same edge: write lands now, result overwrites later.
        op = 2'b00; srcA = 32'd6; srcB = 32'd7; start = 1'b1; loWE = 1'b1; wData = 32'h00001111;
        @(posedge clk); #1;
        start = 1'b0; loWE = 1'b0; srcA = $urandom; srcB = $urandom;
        check("coin lo_write", lo, 32'h00001111);
        check("coin busy", {31'b0, busy}, 32'd1);
        dcyc = 0;
        for (int c = 1; c <= 100 && dcyc == 0; c++) begin
            @(posedge clk); #1;
            if (done) dcyc = c;
        end
        check("coin latency", dcyc, 32'd33);
        check("coin hi", hi, 32'd0);
        check("coin lo", lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
